spi_txc: RTL and testbench
==========================

Name: spi_txc

Overview:
SPI transmit shift core; the send-side counterpart of the SPI receive core in the same clk domain family. It takes parallel words from the TX buffer over a valid/ready handshake and serialises them one bit per clk_tx cycle. It supports 8, 16 and 32-bit frames, with MSB-first or LSB-first order. It counts data frames up to spi_tnum_max and can append one CRC frame, computed serially over the transmitted bits with the same frame width.

Parameters:
None. Frame width and CRC polynomial are run-time inputs.

Ports:
clk_tx  in  1  transmit shift clock, one bit per cycle
spi_tx_rst  in  1  synchronous reset, active-high
spi_en  in  1  transfer enable; low aborts the transfer
df  in  2  frame width: 00=8, 01=16, 10/11=32 bits
lsbf  in  1  1=LSB first, 0=MSB first
crc_en  in  1  append a CRC frame after the data frames
spi_tnum_max  in  13  number of data frames per transfer; 0 is treated as 1
crc_poly  in  32  CRC polynomial; low N bits used
tx_data  in  32  word to send; low N bits used
tx_data_vld  in  1  tx_data valid
tx_data_rdy  out  1  combinational; a word is accepted when vld&rdy
shift_out  out  1  serial data, registered
tx_bit_en  out  1  shift_out carries a valid bit this cycle (SCK gate)
tx_busy  out  1  transfer in progress
tx_num_max_en  out  1  last data frame has been loaded
tx_crc_en  out  1  CRC frame is on the line
tx_done  out  1  one-cycle pulse at end of transfer
tx_crc_data_out  out  32  running CRC register; zero-extended above N

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; CRC register 0. Reset overrides all other events.
- N is 8/16/32 from df. df, lsbf and N are latched at each word load. crc_en, spi_tnum_max and crc_poly are latched at transfer start.
- States:
  - IDLE: tx_data_rdy = spi_en. On accept, load the word, clear frame_cnt and CRC, set tx_busy, go to DATA.
  - DATA: shift_out/tx_bit_en are valid from the cycle after the load edge. bit_cnt runs 0..N-1. Bit order: MSB-first sends tx_data[N-1] down to [0]; LSB-first sends [0] up to [N-1]. On the cycle bit_cnt==N-1, frame_cnt increments.
    - If frames remain: tx_data_rdy=1. An accept in that cycle gives a seamless next frame with no gap. Otherwise go to WAIT.
    - If all frames are sent: go to CRC if crc_en is latched, else go to END.
  - WAIT: tx_bit_en=0, shift_out=0, tx_data_rdy=1. An accept loads the word and returns to DATA. There is no underrun error; the line stalls.
  - CRC: snapshot the CRC register and shift it out MSB first (bit N-1 first) regardless of lsbf. tx_crc_en=1 for exactly the N bit cycles. After the last bit, go to END.
  - END: tx_done=1 for one cycle, tx_busy=0, all flags clear, go to IDLE.
- tx_num_max_en is set when the word with frame index spi_tnum_max-1 is loaded. It clears in END.
- CRC computation:
  - Runs on every DATA bit where tx_bit_en=1, using the bit in wire order.
  - Update: fb = crc[N-1] ^ bit; crc = ((crc<<1) ^ (fb ? poly : 0)) masked to N bits.
  - Initial value 0. No reflection, no final XOR.
  - Frozen during the CRC and WAIT states.
- spi_en falling in any non-IDLE state: next cycle returns to IDLE; tx_busy, tx_bit_en, shift_out and flags go to 0; CRC is cleared; no tx_done.
- A df change between words takes effect only at the next load. bit_cnt never wraps beyond N-1.
- frame_cnt is 13 bits. spi_tnum_max=8191 must complete without overflow.

Optional Feature:
Macro SPI_TXC_CRC_EN.
- Defined: CRC register, CRC state and tx_crc_en are present, as described above.
- Undefined: crc_en is ignored, the CRC state is unreachable, tx_crc_en=0, and tx_crc_data_out=32'h0. The last data frame goes directly to END.

Test Plan:
- df=00, lsbf=0, tnum=1, tx_data=0xA5 -> shift_out 1,0,1,0,0,1,0,1 over 8 cycles with tx_bit_en=1; tx_done the cycle after the last bit; tx_busy 0 after that.
- df=01, lsbf=1, tnum=2, words 0x0001 then 0x8000 held valid -> 32 contiguous tx_bit_en cycles; bits 1 and 32 are 1, all others 0; tx_num_max_en rises at the second load.
- df=00, tnum=2, second tx_data_vld delayed 5 cycles -> 5 WAIT cycles with tx_bit_en=0; then the second frame is sent intact.
- SPI_TXC_CRC_EN, df=00, crc_en=1, poly=0x07, tnum=1, data 0x01 (MSB first) -> data bits 00000001, then CRC frame 00000111 with tx_crc_en=1 for 8 cycles; tx_crc_data_out=0x07.
- df=10, tnum=3, spi_en dropped mid-frame 2 -> IDLE next cycle, all outputs 0, no tx_done; a new transfer then sends correctly from frame 0.
- spi_tx_rst asserted during DATA, with tx_data_vld held high -> all outputs 0 the next cycle; no word is accepted in the reset cycle.

Source files
------------

// File: rtl/spi_txc_if.sv
// Word handshake between the TX buffer and the SPI transmit shift core.
// The buffer side is the master; the shift core is the slave.
interface spi_txc_if;
  logic [31:0] tx_data;
  logic        tx_data_vld;
  logic        tx_data_rdy;

  modport master (output tx_data, output tx_data_vld, input  tx_data_rdy);
  modport slave  (input  tx_data, input  tx_data_vld, output tx_data_rdy);
endinterface

// File: rtl/spi_txc.sv
// SPI transmit shift core: takes 8/16/32-bit words over a valid/ready
// handshake and serialises one bit per clk_tx, MSB- or LSB-first, counting
// frames up to spi_tnum_max. Defining SPI_TXC_CRC_EN adds a serial CRC over
// the transmitted bits, appended as one extra MSB-first frame.
module spi_txc (
  input  logic        clk_tx,
  input  logic        spi_tx_rst,
  input  logic        spi_en,
  input  logic [1:0]  df,
  input  logic        lsbf,
  input  logic        crc_en,
  input  logic [12:0] spi_tnum_max,
  input  logic [31:0] crc_poly,
  spi_txc_if.slave    tx_if,
  output logic        shift_out,
  output logic        tx_bit_en,
  output logic        tx_busy,
  output logic        tx_num_max_en,
  output logic        tx_crc_en,
  output logic        tx_done,
  output logic [31:0] tx_crc_data_out
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_CRC, S_END} state_e;

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;          // frame being shifted (data or CRC snapshot)
  logic [4:0]  last_q, last_d;          // N-1 of the frame being shifted
  logic        lsb_q, lsb_d;            // effective bit order of that frame
  logic [4:0]  bit_cnt_q, bit_cnt_d;    // index of the bit currently on the line
  logic [12:0] frame_cnt_q, frame_cnt_d;
  logic [12:0] tnum_q, tnum_d;
  logic        shift_q, shift_d;
  logic        bit_en_q, bit_en_d;
  logic        busy_q, busy_d;
  logic        num_max_q, num_max_d;
  logic        crc_flag_q, crc_flag_d;
  logic        done_q, done_d;
  logic        rdy, accept, last_bit, frames_left;

`ifdef SPI_TXC_CRC_EN
  logic        crc_en_q, crc_en_d;
  logic [31:0] poly_q, poly_d;
  logic [31:0] crc_q, crc_d;
`else
  logic        unused_crc_inputs;
  assign unused_crc_inputs = ^{crc_en, crc_poly};
`endif

  function automatic logic [4:0] last_idx(input logic [1:0] f);
    logic [4:0] r;
    case (f)
      2'b00:   r = 5'd7;
      2'b01:   r = 5'd15;
      default: r = 5'd31;
    endcase
    return r;
  endfunction

  function automatic logic pick_bit(input logic [31:0] w, input logic [4:0] last,
                                    input logic lsb, input logic [4:0] cnt);
    logic [4:0] pos;
    pos = lsb ? cnt : (last - cnt);
    return w[pos];
  endfunction

`ifdef SPI_TXC_CRC_EN
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] poly,
                                           input logic [4:0] last, input logic b);
    logic        fb;
    logic [31:0] mask;
    fb   = crc[last] ^ b;
    mask = (32'd2 << last) - 32'd1;  // last=31 wraps to all ones
    return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
  endfunction
`endif

  assign last_bit    = (bit_cnt_q == last_q);
  assign frames_left = ({1'b0, frame_cnt_q} + 14'd1) < {1'b0, tnum_q};

  // Ready is combinational on state; reset and a low enable block any accept.
  always_comb begin
    rdy = 1'b0;
    if (!spi_tx_rst && spi_en) begin
      case (state_q)
        S_IDLE, S_WAIT: rdy = 1'b1;
        S_DATA:         rdy = last_bit && frames_left;
        default:        rdy = 1'b0;
      endcase
    end
  end

  assign tx_if.tx_data_rdy = rdy;
  assign accept            = rdy & tx_if.tx_data_vld;

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every _d signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    word_d      = word_q;
    last_d      = last_q;
    lsb_d       = lsb_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    tnum_d      = tnum_q;
    busy_d      = busy_q;
    num_max_d   = num_max_q;
    shift_d     = 1'b0;
    bit_en_d    = 1'b0;
    crc_flag_d  = 1'b0;
    done_d      = 1'b0;
`ifdef SPI_TXC_CRC_EN
    crc_en_d    = crc_en_q;
    poly_d      = poly_q;
    crc_d       = crc_q;
`endif
    if (!spi_en) begin
      // Abort: drop straight back to IDLE without a done pulse.
      if (state_q != S_IDLE) begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        num_max_d   = 1'b0;
        bit_cnt_d   = '0;
        frame_cnt_d = '0;
`ifdef SPI_TXC_CRC_EN
        crc_d       = '0;
`endif
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            frame_cnt_d = '0;
            tnum_d      = (spi_tnum_max == 13'd0) ? 13'd1 : spi_tnum_max;
            busy_d      = 1'b1;
            num_max_d   = 1'b0;
`ifdef SPI_TXC_CRC_EN
            crc_en_d    = crc_en;
            poly_d      = crc_poly;
            crc_d       = '0;
`endif
          end
        end
        S_DATA: begin
`ifdef SPI_TXC_CRC_EN
          crc_d = crc_step(crc_q, poly_q, last_q, shift_q);
`endif
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shift_d   = pick_bit(word_q, last_q, lsb_q, bit_cnt_q + 5'd1);
            bit_en_d  = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 13'd1;
            if (frames_left) begin
              state_d = S_WAIT;  // overridden below by a seamless accept
            end
`ifdef SPI_TXC_CRC_EN
            else if (crc_en_q) begin
              state_d    = S_CRC;
              word_d     = crc_d;
              lsb_d      = 1'b0;
              bit_cnt_d  = '0;
              shift_d    = crc_d[last_q];
              bit_en_d   = 1'b1;
              crc_flag_d = 1'b1;
            end
`endif
            else begin
              state_d   = S_END;
              busy_d    = 1'b0;
              num_max_d = 1'b0;
              done_d    = 1'b1;
            end
          end
        end
        S_CRC: begin
          if (!last_bit) begin
            bit_cnt_d  = bit_cnt_q + 5'd1;
            shift_d    = pick_bit(word_q, last_q, lsb_q, bit_cnt_q + 5'd1);
            bit_en_d   = 1'b1;
            crc_flag_d = 1'b1;
          end else begin
            state_d   = S_END;
            busy_d    = 1'b0;
            num_max_d = 1'b0;
            done_d    = 1'b1;
          end
        end
        S_END:   state_d = S_IDLE;
        default: state_d = state_q;  // S_WAIT holds until accept
      endcase

      // Word load, shared by transfer start, seamless reload and WAIT exit.
      if (accept) begin
        state_d   = S_DATA;
        word_d    = tx_if.tx_data;
        last_d    = last_idx(df);
        lsb_d     = lsbf;
        bit_cnt_d = '0;
        shift_d   = pick_bit(tx_if.tx_data, last_idx(df), lsbf, 5'd0);
        bit_en_d  = 1'b1;
        num_max_d = num_max_d | (frame_cnt_d == (tnum_d - 13'd1));
      end
    end
  end

  // Register update with synchronous active-high reset.
  always_ff @(posedge clk_tx) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (spi_tx_rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      last_q      <= '0;
      lsb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      tnum_q      <= '0;
      shift_q     <= 1'b0;
      bit_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      num_max_q   <= 1'b0;
      crc_flag_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef SPI_TXC_CRC_EN
      crc_en_q    <= 1'b0;
      poly_q      <= '0;
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      last_q      <= last_d;
      lsb_q       <= lsb_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tnum_q      <= tnum_d;
      shift_q     <= shift_d;
      bit_en_q    <= bit_en_d;
      busy_q      <= busy_d;
      num_max_q   <= num_max_d;
      crc_flag_q  <= crc_flag_d;
      done_q      <= done_d;
`ifdef SPI_TXC_CRC_EN
      crc_en_q    <= crc_en_d;
      poly_q      <= poly_d;
      crc_q       <= crc_d;
`endif
    end
  end

  assign shift_out     = shift_q;
  assign tx_bit_en     = bit_en_q;
  assign tx_busy       = busy_q;
  assign tx_num_max_en = num_max_q;
  assign tx_crc_en     = crc_flag_q;
  assign tx_done       = done_q;
`ifdef SPI_TXC_CRC_EN
  assign tx_crc_data_out = crc_q;
`else
  assign tx_crc_data_out = 32'h0;
`endif

endmodule

// File: tb/tb_spi_txc.sv
// Self-checking bench for spi_txc. Expected line activity is derived from
// the word list: each word becomes N wire bits in the configured order, gaps
// become idle WAIT cycles, and the CRC (when SPI_TXC_CRC_EN is defined) is
// computed arithmetically over the wire bits and expected as a trailing frame.
module tb_spi_txc;

  logic        clk_tx = 1'b0;
  logic        spi_tx_rst, spi_en, lsbf, crc_en;
  logic [1:0]  df;
  logic [12:0] spi_tnum_max;
  logic [31:0] crc_poly;
  logic        shift_out, tx_bit_en, tx_busy, tx_num_max_en, tx_crc_en, tx_done;
  logic [31:0] tx_crc_data_out;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] words [16];
  int          gaps  [16];

`ifdef SPI_TXC_CRC_EN
  localparam bit CRC_BUILT = 1'b1;
`else
  localparam bit CRC_BUILT = 1'b0;
`endif

  always #5 clk_tx = ~clk_tx;

  spi_txc_if bus ();

  spi_txc dut (
    .clk_tx          (clk_tx),
    .spi_tx_rst      (spi_tx_rst),
    .spi_en          (spi_en),
    .df              (df),
    .lsbf            (lsbf),
    .crc_en          (crc_en),
    .spi_tnum_max    (spi_tnum_max),
    .crc_poly        (crc_poly),
    .tx_if           (bus),
    .shift_out       (shift_out),
    .tx_bit_en       (tx_bit_en),
    .tx_busy         (tx_busy),
    .tx_num_max_en   (tx_num_max_en),
    .tx_crc_en       (tx_crc_en),
    .tx_done         (tx_done),
    .tx_crc_data_out (tx_crc_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic string tg(input string name, input int k, input int i);
    return $sformatf("%s[%0d.%0d]", name, k, i);
  endfunction

  // CRC of one more wire bit, straight from the shift-register definition.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [31:0] p,
                                           input int n, input logic b);
    logic [31:0] mask;
    logic        fb;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    fb   = c[n-1] ^ b;
    return ((c << 1) ^ (fb ? p : 32'd0)) & mask;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_shift"}, shift_out, 0);
    check({tag, "_bit_en"}, tx_bit_en, 0);
    check({tag, "_busy"}, tx_busy, 0);
    check({tag, "_num_max"}, tx_num_max_en, 0);
    check({tag, "_crc_en"}, tx_crc_en, 0);
    check({tag, "_done"}, tx_done, 0);
    check({tag, "_crc_out"}, tx_crc_data_out, 0);
  endtask

  // One transfer. stop_kind: 0 none, 1 drop spi_en, 2 assert reset,
  // applied during bit stop_i of frame stop_k.
  task automatic run_xfer(input logic [1:0] f, input logic lsb, input logic ce,
                          input int tnum_in, input logic [31:0] poly,
                          input int stop_kind, input int stop_k, input int stop_i);
    int          n, tn;
    logic        crc_on, b;
    logic [31:0] crc;
    n      = (f == 2'b00) ? 8 : (f == 2'b01) ? 16 : 32;
    tn     = (tnum_in == 0) ? 1 : tnum_in;
    crc_on = CRC_BUILT && ce;
    crc    = '0;
    @(negedge clk_tx);
    spi_en = 1'b1; df = f; lsbf = lsb; crc_en = ce;
    spi_tnum_max = 13'(tnum_in); crc_poly = poly;
    bus.tx_data = words[0]; bus.tx_data_vld = 1'b1;
    #1 check("start_rdy", bus.tx_data_rdy, 1);
    for (int k = 0; k < tn; k++) begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk_tx);
        b = lsb ? words[k][i] : words[k][n-1-i];
        check(tg("bit", k, i), shift_out, b);
        check(tg("bit_en", k, i), tx_bit_en, 1);
        check(tg("busy", k, i), tx_busy, 1);
        check(tg("num_max", k, i), tx_num_max_en, (k == tn - 1));
        check(tg("crc_flag", k, i), tx_crc_en, 0);
        check(tg("done", k, i), tx_done, 0);
        check(tg("crc_run", k, i), tx_crc_data_out, CRC_BUILT ? crc : 32'd0);
        if (i == 0) begin
          if (k + 1 < tn && gaps[k+1] == 0) bus.tx_data = words[k+1];
          else bus.tx_data_vld = 1'b0;
          if (k == tn - 1) begin
            // These are latched earlier and must not affect the tail.
            df = f ^ 2'b01; lsbf = ~lsb; crc_en = ~ce; crc_poly = ~poly;
            spi_tnum_max = 13'($urandom);
          end
        end
        #1 check(tg("rdy", k, i), bus.tx_data_rdy, (i == n - 1 && k < tn - 1));
        crc = crc_next(crc, poly, n, b);
        if (stop_kind != 0 && k == stop_k && i == stop_i) begin
          if (stop_kind == 1) begin
            spi_en = 1'b0;
            #1 check("abort_rdy", bus.tx_data_rdy, 0);
          end else begin
            spi_tx_rst = 1'b1; bus.tx_data_vld = 1'b1;
            #1 check("rst_rdy", bus.tx_data_rdy, 0);
          end
          @(negedge clk_tx);
          check_quiet(stop_kind == 1 ? "abort" : "rst");
          spi_tx_rst = 1'b0; bus.tx_data_vld = 1'b0;
          for (int j = 0; j < 3; j++) begin
            @(negedge clk_tx);
            check(tg("after_stop_done", j, 0), tx_done, 0);
            check(tg("after_stop_busy", j, 0), tx_busy, 0);
          end
          spi_en = 1'b1;
          return;
        end
      end
      if (k < tn - 1) begin
        for (int g = 1; g <= gaps[k+1]; g++) begin
          @(negedge clk_tx);
          check(tg("wait_bit_en", k, g), tx_bit_en, 0);
          check(tg("wait_shift", k, g), shift_out, 0);
          check(tg("wait_busy", k, g), tx_busy, 1);
          check(tg("wait_num_max", k, g), tx_num_max_en, 0);
          if (g == gaps[k+1]) begin
            bus.tx_data = words[k+1]; bus.tx_data_vld = 1'b1;
          end
          #1 check(tg("wait_rdy", k, g), bus.tx_data_rdy, 1);
        end
      end
    end
    if (crc_on) begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk_tx);
        check(tg("crc_bit", 0, i), shift_out, crc[n-1-i]);
        check(tg("crc_bit_en", 0, i), tx_bit_en, 1);
        check(tg("crc_flag", 0, i), tx_crc_en, 1);
        check(tg("crc_busy", 0, i), tx_busy, 1);
        check(tg("crc_num_max", 0, i), tx_num_max_en, 1);
        check(tg("crc_value", 0, i), tx_crc_data_out, crc);
        #1 check(tg("crc_rdy", 0, i), bus.tx_data_rdy, 0);
      end
    end
    @(negedge clk_tx);
    check("end_done", tx_done, 1);
    check("end_busy", tx_busy, 0);
    check("end_bit_en", tx_bit_en, 0);
    check("end_shift", shift_out, 0);
    check("end_crc_flag", tx_crc_en, 0);
    check("end_num_max", tx_num_max_en, 0);
    #1 check("end_rdy", bus.tx_data_rdy, 0);
    @(negedge clk_tx);
    check("post_done", tx_done, 0);
    check("post_busy", tx_busy, 0);
    check("post_bit_en", tx_bit_en, 0);
    #1 check("post_rdy", bus.tx_data_rdy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_tx_rst = 1'b1; spi_en = 1'b1; df = 2'b00; lsbf = 1'b0; crc_en = 1'b0;
    spi_tnum_max = 13'd1; crc_poly = '0;
    bus.tx_data = 32'hA5; bus.tx_data_vld = 1'b1;
    foreach (gaps[j]) gaps[j] = 0;

    // Reset state; ready is held off while reset is asserted.
    @(negedge clk_tx); @(negedge clk_tx);
    check_quiet("reset");
    #1 check("reset_rdy", bus.tx_data_rdy, 0);
    spi_tx_rst = 1'b0; bus.tx_data_vld = 1'b0;
    @(negedge clk_tx);
    #1 check("idle_rdy_en", bus.tx_data_rdy, 1);
    spi_en = 1'b0;
    #1 check("idle_rdy_dis", bus.tx_data_rdy, 0);
    spi_en = 1'b1;

    // 8-bit MSB-first single word 0xA5; upper word bits must be ignored.
    words[0] = 32'h1234_56A5;
    run_xfer(2'b00, 1'b0, 1'b0, 1, 32'h0, 0, 0, 0);

    // 16-bit LSB-first, two words back to back.
    words[0] = 32'h0000_0001; words[1] = 32'h0000_8000;
    run_xfer(2'b01, 1'b1, 1'b0, 2, 32'h0, 0, 0, 0);

    // 8-bit, second word delayed by 5 cycles.
    words[0] = $urandom; words[1] = $urandom; gaps[1] = 5;
    run_xfer(2'b00, 1'($urandom), 1'b0, 2, 32'h0, 0, 0, 0);
    gaps[1] = 0;

    // CRC-8 poly 0x07 over data 0x01.
    words[0] = 32'h01;
    run_xfer(2'b00, 1'b0, 1'b1, 1, 32'h07, 0, 0, 0);

    // 32-bit, three frames, enable dropped mid second frame, then a clean run.
    for (int j = 0; j < 3; j++) words[j] = $urandom;
    run_xfer(2'b10, 1'b0, 1'b1, 3, 32'h04C1_1DB7, 1, 1, 13);
    for (int j = 0; j < 3; j++) words[j] = $urandom;
    run_xfer(2'b10, 1'b0, 1'b1, 3, 32'h04C1_1DB7, 0, 0, 0);

    // Reset at the last bit of frame 0 while the next word is valid.
    words[0] = $urandom; words[1] = $urandom;
    run_xfer(2'b01, 1'b0, 1'b0, 2, 32'h0, 2, 0, 15);

    // spi_tnum_max = 0 behaves as a single frame.
    words[0] = $urandom;
    run_xfer(2'b11, 1'b1, 1'b1, 0, $urandom, 0, 0, 0);

    // Randomised transfers.
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 16; j++) begin
        words[j] = $urandom;
        gaps[j]  = (j == 0) ? 0 : int'($urandom_range(0, 3));
      end
      run_xfer(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 4)), $urandom, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
